doodlejump_soc_usb_irq_in: RTL and testbench

DOODLEJUMP_SOC_USB_IRQ_IN -- requirements
Module: doodlejump_soc_usb_irq_in

---
 rtl/doodlejump_soc_usb_irq_in.sv | 97 +++++++++
 tb/tb_doodlejump_soc_usb_irq_in.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/doodlejump_soc_usb_irq_in.sv
// Avalon-MM edge-capturing input port with maskable level interrupt for USB controller status lines.
// Define USB_IRQ_IN_SYNC_EN to put a two-flop synchronizer in front of edge detection instead of a single register.
module doodlejump_soc_usb_irq_in #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] dSync_q;
  logic [WIDTH-1:0] dPrev_q;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] wrData;
  logic             wrEn;
  logic             unusedWrData;

`ifdef USB_IRQ_IN_SYNC_EN
  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      dSync_q <= '0;
    end else begin
      meta_q  <= in_port;
      dSync_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dSync_q <= '0;
    end else begin
      dSync_q <= in_port;
    end
  end
`endif

  assign wrEn         = chipselect & ~write_n;
  assign wrData       = writedata[WIDTH-1:0];
  assign unusedWrData = ^writedata;
  assign risePulse    = dSync_q & ~dPrev_q;

  always_comb begin
    irqMask_d = irqMask_q;
    if (wrEn && address == 2'd2) begin
      irqMask_d = wrData;
    end
  end

  // A fresh rising edge is OR-ed in after the clear so set wins on a collision.
  always_comb begin
    edgeCap_d = edgeCap_q;
    if (wrEn && address == 2'd3) begin
      edgeCap_d = edgeCap_q & ~wrData;
    end
    edgeCap_d = edgeCap_d | risePulse;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = dSync_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqMask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgeCap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dPrev_q    <= '0;
      irqMask_q  <= '0;
      edgeCap_q  <= '0;
      readdata_q <= '0;
    end else begin
      dPrev_q    <= dSync_q;
      irqMask_q  <= irqMask_d;
      edgeCap_q  <= edgeCap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_doodlejump_soc_usb_irq_in.sv
// Randomized and directed bench for doodlejump_soc_usb_irq_in against a sample-history reference model.
module tb_doodlejump_soc_usb_irq_in;

  localparam int WIDTH = 4;
`ifdef USB_IRQ_IN_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '0;
  logic [31:0]      readdata;
  logic             irq;

  logic [WIDTH-1:0] inVal = '0;
  int errCount = 0;
  int checkCount = 0;

  // Model state: hist[i] is the in_port value seen i+1 edges ago.
  logic [WIDTH-1:0] hist [0:3];
  logic [WIDTH-1:0] mMask;
  logic [WIDTH-1:0] mCap;
  logic [31:0]      expRd;
  logic             expIrq;

  doodlejump_soc_usb_irq_in #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    mMask  = '0;
    mCap   = '0;
    expRd  = '0;
    expIrq = 1'b0;
  endtask

  // The synchronized value is the sample LAG edges old; an edge is captured when it rose between consecutive samples.
  task automatic modelEdge(input logic [1:0] addr, input logic cs, input logic wn, input logic [31:0] wd, input logic [WIDTH-1:0] inp);
    logic             wr;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] rise;
    wr   = cs && !wn;
    wdat = wd[WIDTH-1:0];
    case (addr)
      2'd0:    expRd = 32'(hist[LAG-1]);
      2'd2:    expRd = 32'(mMask);
      2'd3:    expRd = 32'(mCap);
      default: expRd = 32'd0;
    endcase
    rise = hist[LAG-1] & ~hist[LAG];
    if (wr && addr == 2'd3) mCap = mCap & ~wdat;
    mCap = mCap | rise;
    if (wr && addr == 2'd2) mMask = wdat;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = inp;
    expIrq = |(mCap & mMask);
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wn, input logic [31:0] wd, input string tag);
    address    = addr;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = inVal;
    @(posedge clk);
    modelEdge(addr, cs, wn, wd, inVal);
    @(negedge clk);
    checkOutput({tag, "/rd"}, readdata, expRd);
    checkOutput({tag, "/irq"}, {31'd0, irq}, {31'd0, expIrq});
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] wd, input string tag);
    applyStimulus(addr, 1'b1, 1'b0, wd, tag);
  endtask

  task automatic readReg(input logic [1:0] addr, input string tag);
    applyStimulus(addr, 1'b1, 1'b1, 32'd0, tag);
  endtask

  task automatic doReset(input string tag);
    reset_n = 1'b0;
    #1;
    checkOutput({tag, "/rst_rd"}, readdata, 32'd0);
    checkOutput({tag, "/rst_irq"}, {31'd0, irq}, 32'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    modelReset();
    inVal = '0;
    #2;
    doReset("init");
    readReg(2'd0, "post_rst_data");
    readReg(2'd2, "post_rst_mask");
    readReg(2'd3, "post_rst_cap");
    readReg(2'd1, "post_rst_rsvd");

    // Rising edges on bits 0 and 2 with only bit 0 unmasked.
    writeReg(2'd2, 32'hFFFF_FFF1, "mask1");
    inVal = 4'b0101;
    for (int i = 0; i < 5; i++) readReg(2'd3, "cap_wait");
    checkOutput("cap0101", readdata, 32'h5);
    checkOutput("irq_cap0101", {31'd0, irq}, 32'd1);
    readReg(2'd0, "data_rd");
    checkOutput("data0101", readdata, 32'h5);

    // Clear bit 0, then unmask bit 2 which is still captured.
    writeReg(2'd3, 32'h1, "clr_bit0");
    checkOutput("irq_after_clr", {31'd0, irq}, 32'd0);
    readReg(2'd3, "cap_after_clr");
    checkOutput("cap0100", readdata, 32'h4);
    writeReg(2'd2, 32'h4, "mask4");
    checkOutput("irq_after_mask4", {31'd0, irq}, 32'd1);

    // Clear of bit 0 lands on the same edge as a new bit-0 capture.
    writeReg(2'd2, 32'h1, "mask_bit0");
    inVal = 4'b0100;
    for (int i = 0; i < LAG + 1; i++) readReg(2'd3, "drop0");
    inVal = 4'b0101;
    readReg(2'd3, "raise0_a");
    for (int i = 0; i < LAG + 1; i++) readReg(2'd3, "cap0_wait");
    checkOutput("irq_bit0", {31'd0, irq}, 32'd1);
    inVal = 4'b0100;
    for (int i = 0; i < LAG + 1; i++) readReg(2'd3, "drop0_b");
    inVal = 4'b0101;
    readReg(2'd3, "raise0_b");
    for (int i = 0; i < LAG - 1; i++) readReg(2'd3, "coincide_wait");
    writeReg(2'd3, 32'h1, "coincide_clr");
    checkOutput("irq_coincide", {31'd0, irq}, 32'd1);
    readReg(2'd3, "cap_coincide");
    checkOutput("cap0_kept", {31'd0, readdata[0]}, 32'd1);

    // Falling edges are ignored and DATA is read-only.
    writeReg(2'd3, 32'hF, "clr_all");
    writeReg(2'd2, 32'hF, "mask_all");
    inVal = 4'b0000;
    for (int i = 0; i < LAG + 3; i++) readReg(2'd3, "fall_wait");
    checkOutput("cap_fall", readdata, 32'h0);
    checkOutput("irq_fall", {31'd0, irq}, 32'd0);
    writeReg(2'd0, 32'hF, "wr_data");
    readReg(2'd0, "data_after_wr");
    checkOutput("data_ro", readdata, 32'h0);

    // Input held high through reset yields one capture after release.
    inVal = 4'b1000;
    doReset("held_high");
    for (int i = 0; i < LAG + 3; i++) readReg(2'd3, "held_wait");
    checkOutput("cap_held", readdata, 32'h8);

    // Reset in the middle of a capture abandons it.
    writeReg(2'd3, 32'hF, "clr_before_mid");
    inVal = 4'b1010;
    readReg(2'd3, "mid_edge");
    inVal = 4'b0000;
    doReset("mid_capture");
    for (int i = 0; i < LAG + 3; i++) readReg(2'd3, "mid_wait");
    checkOutput("cap_mid", readdata, 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) inVal = WIDTH'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        doReset("rnd_reset");
      end else begin
        applyStimulus(2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
